// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO slice:
//   - fifo_depth()        : number of words addressed by an ADDRSIZE-bit pointer
//   - fifo_ptr_width()    : width of the occupancy counter (ADDRSIZE+1), wide
//                           enough to hold the value DEPTH itself
//   - FIFO_MODE_STD/FWFT  : read-mode selectors for the FWFT parameter
//   - fifo_params_ok()    : elaboration-time legality check of the parameters
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic int fifo_ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    // Thresholds must lie where the corresponding flag can both assert and
    // deassert: almost-full in 1..DEPTH, almost-empty in 0..DEPTH-1.
    function automatic bit fifo_params_ok(input int addrsize,
                                          input int afull_th,
                                          input int aempty_th,
                                          input int fwft);
        int depth;
        depth = fifo_depth(addrsize);
        return (addrsize >= 1)
            && (afull_th >= 1) && (afull_th <= depth)
            && (aempty_th >= 0) && (aempty_th <= depth - 1)
            && ((fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// DATASIZE x 2^ADDRSIZE storage array: synchronous write with enable,
// asynchronous (combinational) read.
// Ports:
//   i_clk    : write clock
//   i_w_en   : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data, mem[i_raddr]
// ---------------------------------------------------------------------------
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                i_clk,
    input  logic                i_w_en,
    input  logic [ADDRSIZE-1:0] i_waddr,
    input  logic [DATASIZE-1:0] i_wdata,
    input  logic [ADDRSIZE-1:0] i_raddr,
    output logic [DATASIZE-1:0] o_rdata
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);

    logic [DATASIZE-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; resetting it would force flops
    // instead of RAM, and pointer/count reset already makes contents unreachable.
    // NOTE: clocked state uses <= so every reader sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_w_en) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with integrated storage, registered or first-word-
// fall-through read, programmable almost flags, sticky error flags and a
// synchronous flush.
// Ports:
//   i_clk, i_rst : clock; asynchronous active-high reset
//   i_flush      : synchronous clear of pointers, count and o_rvalid
//   i_clr_err    : synchronous clear of o_overflow / o_underflow
//   i_wdata,i_w_en : write data / request
//   i_r_en       : read request
//   o_rdata      : read data (registered, or head word in FWFT mode)
//   o_rvalid     : o_rdata updated this cycle (registered mode only)
//   o_wfull, o_rempty, o_afull, o_aempty : status decoded from o_count
//   o_count      : occupancy 0..DEPTH
//   o_overflow, o_underflow : sticky error flags
// ---------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_clr_err,
    input  logic [DATASIZE-1:0] i_wdata,
    input  logic                i_w_en,
    input  logic                i_r_en,
    output logic [DATASIZE-1:0] o_rdata,
    output logic                o_rvalid,
    output logic                o_wfull,
    output logic                o_rempty,
    output logic                o_afull,
    output logic                o_aempty,
    output logic [ADDRSIZE:0]   o_count,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);
    localparam int CNT_W = fifo_ptr_width(ADDRSIZE);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(AEMPTY_TH);

    if (!fifo_params_ok(ADDRSIZE, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
        $error("sync_fifo: illegal ADDRSIZE/AFULL_TH/AEMPTY_TH/FWFT combination");
    end

    logic [ADDRSIZE-1:0] wptr;
    logic [ADDRSIZE-1:0] rptr;
    logic [CNT_W-1:0]    count;
    logic [DATASIZE-1:0] ram_rdata;

    // Flush wins over any same-cycle request, so it also masks error events.
    logic wr_acc, rd_acc, ovf_evt, unf_evt;
    assign wr_acc  = i_w_en & ~o_wfull  & ~i_flush;
    assign rd_acc  = i_r_en & ~o_rempty & ~i_flush;
    assign ovf_evt = i_w_en &  o_wfull  & ~i_flush;
    assign unf_evt = i_r_en &  o_rempty & ~i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as i_clr_err keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= (o_overflow  & ~i_clr_err) | ovf_evt;
            o_underflow <= (o_underflow & ~i_clr_err) | unf_evt;
        end
    end

    assign o_count  = count;
    assign o_wfull  = (count == CNT_FULL);
    assign o_rempty = (count == '0);
    assign o_afull  = (count >= CNT_AFULL);
    assign o_aempty = (count <= CNT_AEMPTY);

    sync_fifo_ram #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_w_en  (wr_acc),
        .i_waddr (wptr),
        .i_wdata (i_wdata),
        .i_raddr (rptr),
        .o_rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is always presented; a read simply advances rptr.
        assign o_rdata  = ram_rdata;
        assign o_rvalid = 1'b0;
    end else begin : g_std
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                o_rdata  <= '0;
                o_rvalid <= 1'b0;
            end else begin
                o_rvalid <= rd_acc;
                if (rd_acc) o_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
// Directed, table-driven bench. Two DUTs share one stimulus stream:
// u_std  (DEPTH 4, registered read, AFULL_TH 3, AEMPTY_TH 1)
// u_fwft (same sizing, first-word-fall-through).
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, clr_err, w_en, r_en;
    logic [DW-1:0] wdata;

    logic [DW-1:0] s_rdata, f_rdata;
    logic          s_rvalid, s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_unf;
    logic          f_rvalid, f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    always #5 clk = ~clk;

    sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) u_std (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr_err),
        .i_wdata(wdata), .i_w_en(w_en), .i_r_en(r_en),
        .o_rdata(s_rdata), .o_rvalid(s_rvalid), .o_wfull(s_wfull), .o_rempty(s_rempty),
        .o_afull(s_afull), .o_aempty(s_aempty), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr_err),
        .i_wdata(wdata), .i_w_en(w_en), .i_r_en(r_en),
        .o_rdata(f_rdata), .o_rvalid(f_rvalid), .o_wfull(f_wfull), .o_rempty(f_rempty),
        .o_afull(f_afull), .o_aempty(f_aempty), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flag vector order: {wfull, rempty, afull, aempty, rvalid, overflow, underflow}
    function automatic logic [6:0] s_flags();
        return {s_wfull, s_rempty, s_afull, s_aempty, s_rvalid, s_ovf, s_unf};
    endfunction

    typedef struct {
        logic          w, r, fl, ce;
        logic [DW-1:0] d;
        logic [AW:0]   cnt;
        logic [6:0]    flg;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic r, input logic fl, input logic ce,
                                input logic [DW-1:0] d, input logic [AW:0] cnt,
                                input logic [6:0] flg, input logic [DW-1:0] rd);
        vec_t v;
        v.w = w; v.r = r; v.fl = fl; v.ce = ce; v.d = d;
        v.cnt = cnt; v.flg = flg; v.rd = rd;
        return v;
    endfunction

    initial begin
        rst = 1'b1; flush = 0; clr_err = 0; w_en = 0; r_en = 0; wdata = '0;

        //          w  r  fl ce  data    cnt  flags        rdata
        // Fill to full, overflow, clear
        vecs.push_back(mk(1, 0, 0, 0, 8'h11, 1, 7'b0001000, 8'h00));
        vecs.push_back(mk(1, 0, 0, 0, 8'h22, 2, 7'b0000000, 8'h00));
        vecs.push_back(mk(1, 0, 0, 0, 8'h33, 3, 7'b0010000, 8'h00));
        vecs.push_back(mk(1, 0, 0, 0, 8'h44, 4, 7'b1010000, 8'h00));
        vecs.push_back(mk(1, 0, 0, 0, 8'h55, 4, 7'b1010010, 8'h00));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 4, 7'b1010000, 8'h00));
        // Drain, underflow, clear
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 3, 7'b0010100, 8'h11));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 2, 7'b0000100, 8'h22));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 7'b0001100, 8'h33));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 7'b0101100, 8'h44));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 7'b0101001, 8'h44));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 7'b0101000, 8'h44));
        // Wrap-around with count held at 2
        vecs.push_back(mk(1, 0, 0, 0, 8'h01, 1, 7'b0001000, 8'h44));
        vecs.push_back(mk(1, 0, 0, 0, 8'h02, 2, 7'b0000000, 8'h44));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 1, 0, 0, 8'(8'h03 + i), 2, 7'b0000100, 8'(8'h01 + i)));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 7'b0001100, 8'h07));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 7'b0101100, 8'h08));
        // Full + simultaneous read/write: write rejected, read accepted
        vecs.push_back(mk(1, 0, 0, 0, 8'hA0, 1, 7'b0001000, 8'h08));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA1, 2, 7'b0000000, 8'h08));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA2, 3, 7'b0010000, 8'h08));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA3, 4, 7'b1010000, 8'h08));
        vecs.push_back(mk(1, 1, 0, 0, 8'hFF, 3, 7'b0010110, 8'hA0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 3, 7'b0010000, 8'hA0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 2, 7'b0000100, 8'hA1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 7'b0001100, 8'hA2));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 7'b0101100, 8'hA3));
        // Empty + simultaneous read/write: read rejected, write accepted
        vecs.push_back(mk(1, 1, 0, 0, 8'hBB, 1, 7'b0001001, 8'hA3));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 1, 7'b0001000, 8'hA3));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 7'b0101100, 8'hBB));
        // Flush at count 3 with write and read requested
        vecs.push_back(mk(1, 0, 0, 0, 8'hC1, 1, 7'b0001000, 8'hBB));
        vecs.push_back(mk(1, 0, 0, 0, 8'hC2, 2, 7'b0000000, 8'hBB));
        vecs.push_back(mk(1, 0, 0, 0, 8'hC3, 3, 7'b0010000, 8'hBB));
        vecs.push_back(mk(1, 1, 1, 0, 8'hDD, 0, 7'b0101000, 8'hBB));

        // Reset state, observed while reset is still asserted
        #2;
        check("reset_count", 32'(s_count), 32'd0);
        check("reset_flags", 32'(s_flags()), 32'b0101000);
        check("reset_rdata", 32'(s_rdata), 32'h00);
        check("reset_fwft_empty", 32'(f_rempty), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            w_en = vecs[i].w; r_en = vecs[i].r; flush = vecs[i].fl;
            clr_err = vecs[i].ce; wdata = vecs[i].d;
            tick();
            check($sformatf("v%0d_count", i), 32'(s_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_flags", i), 32'(s_flags()), 32'(vecs[i].flg));
            check($sformatf("v%0d_rdata", i), 32'(s_rdata), 32'(vecs[i].rd));
        end
        w_en = 0; r_en = 0; flush = 0; clr_err = 0;

        // FWFT: head word visible the cycle after the write, without a read
        w_en = 1; wdata = 8'hA5;
        tick();
        w_en = 0;
        check("fwft_empty_after_wr", 32'(f_rempty), 32'd0);
        check("fwft_head", 32'(f_rdata), 32'hA5);
        check("fwft_rvalid_tied", 32'(f_rvalid), 32'd0);
        tick();
        check("fwft_head_hold", 32'(f_rdata), 32'hA5);
        w_en = 1; wdata = 8'h5A;
        tick();
        w_en = 0;
        check("fwft_head_not_tail", 32'(f_rdata), 32'hA5);
        check("fwft_count2", 32'(f_count), 32'd2);
        r_en = 1;
        tick();
        check("fwft_next_head", 32'(f_rdata), 32'h5A);
        tick();
        r_en = 0;
        check("fwft_empty_after_rd", 32'(f_rempty), 32'd1);
        check("fwft_no_underflow", 32'(f_unf), 32'd0);

        // Reset asserted mid-burst acts without a clock edge
        w_en = 1; wdata = 8'h01;
        tick();
        wdata = 8'h02;
        tick();
        check("burst_count", 32'(s_count), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_count", 32'(s_count), 32'd0);
        check("midrst_flags", 32'(s_flags()), 32'b0101000);
        check("midrst_rdata", 32'(s_rdata), 32'h00);
        check("midrst_fwft_count", 32'(f_count), 32'd0);
        w_en = 0;
        @(negedge clk);
        rst = 1'b0;

        // Operation resumes from pointer 0 after reset
        w_en = 1; wdata = 8'h77;
        tick();
        w_en = 0; r_en = 1;
        tick();
        r_en = 0;
        check("post_rst_rdata", 32'(s_rdata), 32'h77);
        check("post_rst_rvalid", 32'(s_rvalid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
